uni_to_bin_acc: RTL and testbench

Unary-to-binary accumulator sitting directly downstream of `dMUL_uni`. It counts the ones in the `oC` product bitstream over one full window of 2^INWD cycles and returns the binary product count on a valid/ready output port. Its `start` pulse is driven together with the multiplier's `loadA`/`loadB`. A programmable skip absorbs the multiplier's pipeline latency so the counting window aligns with the multiplier's first valid output bit.

---
 rtl/uni_to_bin_acc.sv | 136 +++++++++++++
 tb/tb_uni_to_bin_acc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uni_to_bin_acc.sv
// Unary-to-binary accumulator: counts the ones of a 2^INWD-bit product stream
// and presents the binary count on a valid/ready port.
module uni_to_bin_acc #(
  parameter int INWD = 8,
  parameter int SKIP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            iBit,
  input  logic            iReady,
  output logic [INWD:0]   oData,
  output logic            oValid,
  output logic            oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int              SKIP_M1   = (SKIP > 0) ? SKIP - 1 : 0;
  localparam logic [3:0]      SKIP_LOAD = SKIP_M1[3:0];
  localparam bit              NO_SKIP   = (SKIP == 0);
  localparam logic [INWD-1:0] WIN_LAST  = {INWD{1'b1}};

  state_t            state_r, state_nxt_s;
  logic [3:0]        skip_r, skip_nxt_s;
  logic [INWD-1:0]   win_r, win_nxt_s;
  logic [INWD:0]     ones_r, ones_nxt_s;
  logic [INWD:0]     data_r, data_nxt_s;
  logic              valid_r, busy_r;
  logic              launch_s, count_s;

  // Next-state, counter and result logic; the edge that enters ACC also counts its bit.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_r;
    win_nxt_s   = win_r;
    ones_nxt_s  = ones_r;
    data_nxt_s  = data_r;
    launch_s    = 1'b0;
    count_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          launch_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (skip_r == 4'd0) begin
          state_nxt_s = ACC;
          count_s     = 1'b1;
        end else begin
          skip_nxt_s = skip_r - 4'd1;
        end
      end
      ACC: begin
        count_s = 1'b1;
      end
      DONE: begin
        if (iReady) begin
          if (start) begin
            launch_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // A new window always starts from cleared counters.
    if (launch_s) begin
      win_nxt_s  = {INWD{1'b0}};
      ones_nxt_s = {(INWD+1){1'b0}};
      if (NO_SKIP) begin
        state_nxt_s = ACC;
        count_s     = 1'b1;
      end else begin
        state_nxt_s = WAIT;
        skip_nxt_s  = SKIP_LOAD;
      end
    end else begin
      win_nxt_s = win_nxt_s;
    end

    if (count_s) begin
      ones_nxt_s = ones_nxt_s + {{INWD{1'b0}}, iBit};
      if (win_nxt_s == WIN_LAST) begin
        state_nxt_s = DONE;
        data_nxt_s  = ones_nxt_s;
      end else begin
        data_nxt_s = data_r;
      end
      win_nxt_s = win_nxt_s + {{(INWD-1){1'b0}}, 1'b1};
    end else begin
      ones_nxt_s = ones_nxt_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      skip_r  <= 4'd0;
      win_r   <= {INWD{1'b0}};
      ones_r  <= {(INWD+1){1'b0}};
      data_r  <= {(INWD+1){1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      skip_r  <= skip_nxt_s;
      win_r   <= win_nxt_s;
      ones_r  <= ones_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= (state_nxt_s == DONE);
      busy_r  <= (state_nxt_s == WAIT) || (state_nxt_s == ACC);
    end
  end

  assign oData  = data_r;
  assign oValid = valid_r;
  assign oBusy  = busy_r;

endmodule

// File: tb/tb_uni_to_bin_acc.sv
// Directed bench: instance 0 runs with SKIP=1, instance 1 with SKIP=0; iBit
// patterns stand in for the multiplier's product stream.
module tb_uni_to_bin_acc;

  logic       clk = 1'b0;
  logic       rst_v   [2];
  logic       start_v [2];
  logic       ibit_v  [2];
  logic       ready_v [2];
  logic [8:0] data_v  [2];
  logic       valid_v [2];
  logic       busy_v  [2];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uni_to_bin_acc #(.INWD(8), .SKIP(1)) u_s1 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .iBit(ibit_v[0]), .iReady(ready_v[0]),
    .oData(data_v[0]), .oValid(valid_v[0]), .oBusy(busy_v[0]));

  uni_to_bin_acc #(.INWD(8), .SKIP(0)) u_s0 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .iBit(ibit_v[1]), .iReady(ready_v[1]),
    .oData(data_v[1]), .oValid(valid_v[1]), .oBusy(busy_v[1]));

  // mode 2: 64 ones, 3: 254 ones, 4: 32 ones, 1: all ones, 0: all zeros
  function automatic logic pat(input int mode, input int k);
    case (mode)
      1: return 1'b1;
      2: return (k % 4 == 0);
      3: return (k < 254);
      4: return (k % 8 == 5);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one window from IDLE (or from DONE when b2b=1); iBit is 1 outside the window.
  task automatic run_window(input int d, input int mode, input int exp_cnt,
                            input logic [8:0] prev, input bit b2b,
                            input int restart_j, input string name);
    int sk;
    int first;
    int busy_bad;
    int valid_bad;
    int hold_bad;
    int k;
    sk = (d == 0) ? 1 : 0;
    first = -1;
    busy_bad = 0;
    valid_bad = 0;
    hold_bad = 0;
    for (int j = 0; j <= sk + 258; j++) begin
      start_v[d] = (j == 0) || (j == restart_j);
      ready_v[d] = b2b && (j == 0);
      k = j - sk;
      ibit_v[d] = (k >= 0 && k < 256) ? pat(mode, k) : 1'b1;
      tick();
      if (valid_v[d] === 1'b1 && first < 0) first = j;
      if (busy_v[d] !== (j < sk + 255)) busy_bad++;
      if (valid_v[d] !== (j >= sk + 255)) valid_bad++;
      if (j < sk + 255 && data_v[d] !== prev) hold_bad++;
    end
    start_v[d] = 1'b0;
    ready_v[d] = 1'b0;
    checks++;
    if (first + 1 !== sk + 256) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, first + 1, sk + 256);
    end
    checks++;
    if (data_v[d] !== 9'(exp_cnt)) begin
      failures++;
      $display("FAIL %s data: got %0d want %0d", name, data_v[d], exp_cnt);
    end
    checks++;
    if (busy_bad != 0 || valid_bad != 0) begin
      failures++;
      $display("FAIL %s busy/valid profile: bad_busy=%0d bad_valid=%0d want 0", name, busy_bad, valid_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL %s data hold: got %0d changed cycles want 0", name, hold_bad);
    end
  endtask

  task automatic handshake(input int d, input logic [8:0] exp, input string name);
    ready_v[d] = 1'b1;
    ibit_v[d]  = 1'b1;
    tick();
    ready_v[d] = 1'b0;
    checks++;
    if (valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s handshake: got valid=%b busy=%b want 0 0", name, valid_v[d], busy_v[d]);
    end
    tick();
    checks++;
    if (data_v[d] !== exp || busy_v[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s idle hold: got data=%0d busy=%b want %0d 0", name, data_v[d], busy_v[d], exp);
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; start_v[d] = 1'b0; ibit_v[d] = 1'b1; ready_v[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b0;
      checks++;
      if (data_v[d] !== 9'd0 || valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: got data=%0d valid=%b busy=%b want 0 0 0", d, data_v[d], valid_v[d], busy_v[d]);
      end
    end
  endtask

  task automatic test_product_skip1;
    run_window(0, 2, 64, 9'd0, 1'b0, -1, "prod64");
    handshake(0, 9'd64, "prod64");
  endtask

  task automatic test_ones_zeros_skip0;
    run_window(1, 1, 256, 9'd0, 1'b0, -1, "ones256");
    handshake(1, 9'd256, "ones256");
    run_window(1, 0, 0, 9'd256, 1'b0, -1, "zeros");
    handshake(1, 9'd0, "zeros");
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    run_window(0, 4, 32, 9'd64, 1'b0, -1, "bp_win");
    for (int i = 0; i < 20; i++) begin
      ready_v[0] = 1'b0;
      start_v[0] = (i == 5);
      ibit_v[0]  = 1'b1;
      tick();
      if (valid_v[0] !== 1'b1 || data_v[0] !== 9'd32 || busy_v[0] !== 1'b0) bad++;
    end
    start_v[0] = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure hold: got %0d bad cycles want 0", bad);
    end
    handshake(0, 9'd32, "bp");
  endtask

  task automatic test_back_to_back;
    run_window(0, 2, 64, 9'd32, 1'b0, -1, "b2b_a");
    run_window(0, 3, 254, 9'd64, 1'b1, -1, "b2b_b");
    handshake(0, 9'd254, "b2b");
    run_window(1, 3, 254, 9'd0, 1'b0, -1, "b2b0_a");
    run_window(1, 1, 256, 9'd254, 1'b1, -1, "b2b0_b");
    handshake(1, 9'd256, "b2b0");
  endtask

  task automatic test_reset_mid;
    for (int j = 0; j <= 101; j++) begin
      start_v[0] = (j == 0);
      ibit_v[0]  = 1'b1;
      tick();
    end
    start_v[0] = 1'b0;
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    checks++;
    if (data_v[0] !== 9'd0 || valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got data=%0d valid=%b busy=%b want 0 0 0", data_v[0], valid_v[0], busy_v[0]);
    end
    tick();
    checks++;
    if (busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid idle: got busy=%b want 0", busy_v[0]);
    end
    run_window(0, 4, 32, 9'd0, 1'b0, -1, "after_rst");
    handshake(0, 9'd32, "after_rst");
  endtask

  task automatic test_restart_mid;
    run_window(0, 2, 64, 9'd32, 1'b0, 100, "restart");
    handshake(0, 9'd64, "restart");
  endtask

  initial begin
    test_reset();
    test_product_skip1();
    test_ones_zeros_skip0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_restart_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
